// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that gate uop issue
// on RAW and WAW-saturation hazards, plus an IDLE/DRAIN flush-drain machine.
module reg_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                iss_valid,
    output logic                                iss_ready,
    input  logic [2:0]                          iss_src_v,
    input  logic [2:0][$clog2(NREGS)-1:0]       iss_src,
    input  logic [1:0]                          iss_dst_v,
    input  logic [1:0][$clog2(NREGS)-1:0]       iss_dst,
    input  logic                                wb_valid,
    input  logic [1:0]                          wb_dst_v,
    input  logic [1:0][$clog2(NREGS)-1:0]       wb_dst,
    input  logic                                flush,
    output logic                                flush_done,
    output logic [NREGS-1:0]                    busy,
    output logic                                all_idle,
    output logic                                err_underflow
);

    localparam int unsigned RW = $clog2(NREGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic                        flush_done_q, flush_done_d;
    logic                        raw_hit, waw_hit, issue;
    logic [NREGS-1:0]            inc, dec;

    // Hazard detection against pre-edge counters only; writeback never bypasses.
    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (iss_src_v[k] && (iss_src[k] == RW'(i)) && (cnt_q[i] != '0)) begin
                    raw_hit = 1'b1;
                end
            end
            for (int unsigned k = 0; k < 2; k++) begin
                if (iss_dst_v[k] && (iss_dst[k] == RW'(i)) && (cnt_q[i] == CNT_MAX)) begin
                    waw_hit = 1'b1;
                end
            end
        end
    end

    assign iss_ready = !reset && (state_q == IDLE) && !flush && !raw_hit && !waw_hit;
    assign issue     = iss_valid && iss_ready;

    // Per-register hit vectors; a register named by both slots counts once.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            inc[i] = issue && ((iss_dst_v[0] && (iss_dst[0] == RW'(i))) ||
                               (iss_dst_v[1] && (iss_dst[1] == RW'(i))));
            dec[i] = wb_valid && ((wb_dst_v[0] && (wb_dst[0] == RW'(i))) ||
                                  (wb_dst_v[1] && (wb_dst[1] == RW'(i))));
        end
    end

    // Counter update: simultaneous inc and dec cancel; dec at zero flags underflow.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (inc[i] && !dec[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec[i] && !inc[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            busy[i] = |cnt_q[i];
        end
    end

    assign all_idle = ~|busy;

    // Flush FSM: DRAIN holds issue off until every pending write has retired.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (all_idle) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign flush_done    = flush_done_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard: hazards, saturation, flush drain,
// underflow and asynchronous reset, with hand-computed expectations.
module tb_reg_scoreboard;

    localparam int unsigned NREGS = 32;
    localparam int unsigned RW    = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [2:0]           iss_src_v;
    logic [2:0][RW-1:0]   iss_src;
    logic [1:0]           iss_dst_v;
    logic [1:0][RW-1:0]   iss_dst;
    logic                 wb_valid;
    logic [1:0]           wb_dst_v;
    logic [1:0][RW-1:0]   wb_dst;
    logic                 flush;
    logic                 flush_done;
    logic [NREGS-1:0]     busy;
    logic                 all_idle;
    logic                 err_underflow;

    int checks   = 0;
    int failures = 0;

    reg_scoreboard #(.NREGS(NREGS), .CNT_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_src_v     (iss_src_v),
        .iss_src       (iss_src),
        .iss_dst_v     (iss_dst_v),
        .iss_dst       (iss_dst),
        .wb_valid      (wb_valid),
        .wb_dst_v      (wb_dst_v),
        .wb_dst        (wb_dst),
        .flush         (flush),
        .flush_done    (flush_done),
        .busy          (busy),
        .all_idle      (all_idle),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic clr();
        iss_valid = 1'b0; iss_src_v = '0; iss_src = '0; iss_dst_v = '0; iss_dst = '0;
        wb_valid  = 1'b0; wb_dst_v  = '0; wb_dst  = '0; flush = 1'b0;
    endtask

    task automatic iss1(input logic [RW-1:0] d);
        iss_valid = 1'b1; iss_dst_v = 2'b01; iss_dst[0] = d;
    endtask

    task automatic wb1(input logic [RW-1:0] d);
        wb_valid = 1'b1; wb_dst_v = 2'b01; wb_dst[0] = d;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr(); reset = 1'b1; iss1(5'd1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", iss_ready); end
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (all_idle !== 1'b1) begin failures++; $display("FAIL rst_all_idle got=%0b exp=1", all_idle); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_underflow); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rst_flush_done got=%0b exp=0", flush_done); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL rst_first_ready got=%0b exp=1", iss_ready); end
        tick(); clr();
        @(negedge clk);
        checks++; if (busy !== 32'h2) begin failures++; $display("FAIL rst_first_issue got=%0h exp=2", busy); end
        wb1(5'd1); tick(); clr();
    endtask

    task automatic test_raw();
        iss1(5'd3); tick(); clr();
        iss_valid = 1'b1; iss_src_v = 3'b001; iss_src[0] = 5'd3;
        @(negedge clk);
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL raw_block got=%0b exp=0", iss_ready); end
        checks++; if (busy[3] !== 1'b1) begin failures++; $display("FAIL raw_busy3 got=%0b exp=1", busy[3]); end
        tick(); wb1(5'd3);
        @(negedge clk);
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL raw_no_bypass got=%0b exp=0", iss_ready); end
        tick(); wb_valid = 1'b0; wb_dst_v = '0;
        @(negedge clk);
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL raw_release got=%0b exp=1", iss_ready); end
        checks++; if (busy[3] !== 1'b0) begin failures++; $display("FAIL raw_busy3_clear got=%0b exp=0", busy[3]); end
        tick(); clr();
    endtask

    task automatic test_waw();
        for (int n = 0; n < 3; n++) begin
            iss1(5'd5);
            @(negedge clk);
            checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL waw_issue%0d got=%0b exp=1", n, iss_ready); end
            tick(); clr();
        end
        iss1(5'd5); wb1(5'd5);
        @(negedge clk);
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL waw_sat_block got=%0b exp=0", iss_ready); end
        tick(); clr(); iss1(5'd5);
        @(negedge clk);
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL waw_after_wb got=%0b exp=1", iss_ready); end
        tick(); clr();
        repeat (2) begin wb1(5'd5); tick(); end
        clr();
        @(negedge clk);
        checks++; if (busy[5] !== 1'b1) begin failures++; $display("FAIL waw_count3 got=%0b exp=1", busy[5]); end
        wb1(5'd5); tick(); clr();
        @(negedge clk);
        checks++; if (busy[5] !== 1'b0) begin failures++; $display("FAIL waw_drained got=%0b exp=0", busy[5]); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL waw_err got=%0b exp=0", err_underflow); end
    endtask

    task automatic test_dual_dst();
        iss_valid = 1'b1; iss_dst_v = 2'b11; iss_dst[0] = 5'd6; iss_dst[1] = 5'd6;
        tick(); clr(); wb1(5'd6); tick(); clr();
        @(negedge clk);
        checks++; if (busy[6] !== 1'b0) begin failures++; $display("FAIL dual_dst_once got=%0b exp=0", busy[6]); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL dual_dst_err got=%0b exp=0", err_underflow); end
        iss1(5'd6); tick(); tick(); clr();
        wb_valid = 1'b1; wb_dst_v = 2'b11; wb_dst[0] = 5'd6; wb_dst[1] = 5'd6;
        tick(); clr();
        @(negedge clk);
        checks++; if (busy[6] !== 1'b1) begin failures++; $display("FAIL dual_wb_once got=%0b exp=1", busy[6]); end
        wb1(5'd6); tick(); clr();
        @(negedge clk);
        checks++; if (busy[6] !== 1'b0) begin failures++; $display("FAIL dual_wb_drain got=%0b exp=0", busy[6]); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL dual_wb_err got=%0b exp=0", err_underflow); end
    endtask

    task automatic test_same_cycle();
        iss1(5'd7); tick(); clr();
        iss1(5'd7); wb1(5'd7);
        @(negedge clk);
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%0b exp=1", iss_ready); end
        tick(); clr();
        @(negedge clk);
        checks++; if (busy[7] !== 1'b1) begin failures++; $display("FAIL same_busy7 got=%0b exp=1", busy[7]); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL same_err got=%0b exp=0", err_underflow); end
        wb1(5'd7); tick(); clr();
        @(negedge clk);
        checks++; if (busy[7] !== 1'b0) begin failures++; $display("FAIL same_count1 got=%0b exp=0", busy[7]); end
    endtask

    task automatic test_flush();
        iss1(5'd2); tick(); iss1(5'd4); tick(); clr();
        flush = 1'b1; iss1(5'd8);
        @(negedge clk);
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL flush_block got=%0b exp=0", iss_ready); end
        tick(); clr(); iss1(5'd8); flush = 1'b1;
        @(negedge clk);
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL drain_block got=%0b exp=0", iss_ready); end
        tick(); clr(); wb1(5'd2); tick(); clr(); wb1(5'd4);
        @(negedge clk);
        checks++; if (all_idle !== 1'b0) begin failures++; $display("FAIL drain_not_idle got=%0b exp=0", all_idle); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL drain_early_done got=%0b exp=0", flush_done); end
        tick(); clr();
        @(negedge clk);
        checks++; if (all_idle !== 1'b1) begin failures++; $display("FAIL drain_idle got=%0b exp=1", all_idle); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL drain_done_same got=%0b exp=0", flush_done); end
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL drain_still got=%0b exp=0", iss_ready); end
        tick();
        @(negedge clk);
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL drain_done got=%0b exp=1", flush_done); end
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL drain_exit_ready got=%0b exp=1", iss_ready); end
        checks++; if (busy[8] !== 1'b0) begin failures++; $display("FAIL drain_no_issue8 got=%0b exp=0", busy[8]); end
        tick();
        @(negedge clk);
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL drain_done_once got=%0b exp=0", flush_done); end
        tick();
    endtask

    task automatic test_flush_idle();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fidle_c0 got=%0b exp=0", flush_done); end
        tick(); clr();
        @(negedge clk);
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL fidle_drain got=%0b exp=0", iss_ready); end
        tick();
        @(negedge clk);
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL fidle_done got=%0b exp=1", flush_done); end
        tick();
        @(negedge clk);
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fidle_once got=%0b exp=0", flush_done); end
        tick();
    endtask

    task automatic test_underflow();
        wb1(5'd9);
        @(negedge clk);
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_pre got=%0b exp=0", err_underflow); end
        tick(); clr();
        @(negedge clk);
        checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%0b exp=1", err_underflow); end
        checks++; if (busy[9] !== 1'b0) begin failures++; $display("FAIL uf_cnt0 got=%0b exp=0", busy[9]); end
        tick();
        @(negedge clk);
        checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0b exp=1", err_underflow); end
        #2 reset = 1'b1;
        #1;
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_reset got=%0b exp=0", err_underflow); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_reset_drain();
        iss1(5'd10); tick(); iss1(5'd11); tick(); clr();
        flush = 1'b1; tick(); clr(); wb1(5'd10); tick(); clr();
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL rd_busy got=%0h exp=0", busy); end
        checks++; if (all_idle !== 1'b1) begin failures++; $display("FAIL rd_idle got=%0b exp=1", all_idle); end
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL rd_ready_rst got=%0b exp=0", iss_ready); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL rd_ready got=%0b exp=1", iss_ready); end
        for (int n = 0; n < 3; n++) begin
            checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rd_no_done%0d got=%0b exp=0", n, flush_done); end
            tick();
            @(negedge clk);
        end
        tick(); iss1(5'd12); tick(); clr();
        @(negedge clk);
        checks++; if (busy !== 32'h1000) begin failures++; $display("FAIL rd_issue got=%0h exp=1000", busy); end
        wb1(5'd12); tick(); clr();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw();
        test_dual_dst();
        test_same_cycle();
        test_flush();
        test_flush_idle();
        test_underflow();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
